// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner for a common-anode, active-low display.
// Optional blinking of selected digits is enabled by defining SEG7_BLINK_EN.
module seg7_scan #(
  parameter int SCAN_DIV  = 17,
  parameter int BLINK_DIV = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_data,
  input  logic [7:0]  point,
  input  logic [7:0]  les,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam logic [SCAN_DIV-1:0] PRESC_ONE = SCAN_DIV'(1);

  logic [SCAN_DIV-1:0] presc_q, presc_d;
  logic [2:0]          idx_q, idx_d;
  logic [31:0]         data_q, data_d;
  logic [7:0]          pt_q, pt_d;
  logic [7:0]          le_q, le_d;
  logic                load_pending_q, load_pending_d;
  logic [7:0]          an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic                tick;
  logic                load;
  logic                blank;
  logic [3:0]          nib;

  // Segment pattern g..a, active-high.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef SEG7_BLINK_EN
  logic [BLINK_DIV-1:0] blink_q, blink_d;

  always_comb blink_d = blink_q + BLINK_DIV'(1);

  always_ff @(posedge clk) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_d;
  end

  assign blank = le_q[idx_q] & blink_q[BLINK_DIV-1];
`else
  // Without the blink option the shadowed les bits are inert.
  assign blank = le_q[idx_q] & (BLINK_DIV < 0);
`endif

  always_comb begin
    // The scan is held at digit 0 until the first shadow load has happened.
    tick           = !load_pending_q && (presc_q == '1);
    presc_d        = load_pending_q ? '0 : presc_q + PRESC_ONE;
    idx_d          = tick ? idx_q + 3'd1 : idx_q;
    load           = load_pending_q || (tick && (idx_q == 3'd7));
    load_pending_d = 1'b0;
    data_d         = load ? disp_data : data_q;
    pt_d           = load ? point     : pt_q;
    le_d           = load ? les       : le_q;
    nib            = data_q[{idx_q, 2'b00} +: 4];
    an_d           = load_pending_q ? 8'hFF : ~(8'b1 << idx_q);
    seg_d          = (load_pending_q || blank) ? 8'hFF : {~pt_q[idx_q], ~hex7(nib)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      idx_q          <= 3'd0;
      data_q         <= 32'h0;
      pt_q           <= 8'h0;
      le_q           <= 8'h0;
      load_pending_q <= 1'b1;
      an_q           <= 8'hFF;
      seg_q          <= 8'hFF;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      data_q         <= data_d;
      pt_q           <= pt_d;
      le_q           <= le_d;
      load_pending_q <= load_pending_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan with SCAN_DIV=2 and BLINK_DIV=4; expected
// display words are queued per cycle by the stimulus and checked by a monitor.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] disp_data = 32'h0123_4567;
  logic [7:0]  point = 8'h00;
  logic [7:0]  les = 8'h00;
  logic [7:0]  an;
  logic [7:0]  seg;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    int         step;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         step_no = 0;
  logic [7:0] lit [8];

  seg7_scan #(.SCAN_DIV(2), .BLINK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .disp_data(disp_data),
    .point(point),
    .les(les),
    .an(an),
    .seg(seg)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and queue what the outputs must show after it.
  task automatic cyc(input logic [7:0] a_e, input logic [7:0] s_e);
    exp_t e;
    @(posedge clk);
    #1;
    e.an   = a_e;
    e.seg  = s_e;
    e.step = step_no;
    step_no++;
    sb_q.push_back(e);
  endtask

  // One scan frame (4 cycles per digit) starting at the first cycle of digit 0.
  task automatic run_frame(input logic [7:0] sv [8], input logic [7:0] le_s,
                           input int ncyc, input int chg_at,
                           input logic [31:0] nd, input logic [7:0] np,
                           input logic [7:0] nl);
    for (int j = 0; j < ncyc; j++) begin
      int         i;
      logic [7:0] a_e;
      logic       bl;
      i      = j / 4;
      a_e    = 8'hFF;
      a_e[i] = 1'b0;
`ifdef SEG7_BLINK_EN
      bl = le_s[i] && (((j + 1) % 16) >= 8);
`else
      bl = 1'b0;
`endif
      cyc(a_e, bl ? 8'hFF : sv[i]);
      if (j == chg_at) begin
        disp_data = nd;
        point     = np;
        les       = nl;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (an !== e.an || seg !== e.seg) begin
          n_bad++;
          $display("FAIL out step=%0d got an=%h seg=%h want an=%h seg=%h",
                   e.step, an, seg, e.an, e.seg);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset held three cycles, then E0 keeps the display dark.
    repeat (3) cyc(8'hFF, 8'hFF);
    rst = 1'b0;
    cyc(8'hFF, 8'hFF);

    // 0123_4567; a new word arriving mid-frame must wait for the boundary.
    lit = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    run_frame(lit, 8'h00, 32, 10, 32'h89AB_CDEF, 8'h00, 8'h00);

    // 89AB_CDEF full frame.
    lit = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    run_frame(lit, 8'h00, 32, 5, 32'h0000_0001, 8'h01, 8'h00);

    // Decimal point on digit 0; data flips to all-F while idx=3.
    lit = '{8'h79, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    run_frame(lit, 8'h00, 32, 12, 32'hFFFF_FFFF, 8'h00, 8'h00);

    // All digits F, interrupted by reset during digit 5.
    lit = '{8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E};
    run_frame(lit, 8'h00, 21, -1, 32'h0, 8'h00, 8'h00);
    rst       = 1'b1;
    disp_data = 32'h0123_4567;
    les       = 8'hA5;
    cyc(8'hFF, 8'hFF);
    rst = 1'b0;
    cyc(8'hFF, 8'hFF);

    // Restarted frame from digit 0 with the word captured on E0; blinking digits per les.
    lit = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    run_frame(lit, 8'hA5, 32, -1, 32'h0, 8'h00, 8'h00);

    for (int w = 0; w < 4 && sb_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Eight-digit multiplexed seven-segment scanner. It sits directly downstream of the 8-to-1 32-bit display-source selector and consumes its 32-bit output. It shows the word as eight hex digits on a common-anode, active-low display. Inputs are captured once per full scan frame, so a digit never shows a mix of old and new data.

## Interface
- SCAN_DIV, 17: prescaler width; each digit is lit for 2^SCAN_DIV clk cycles.
- BLINK_DIV, 24: blink counter width; blink phase = counter MSB (only with SEG7_BLINK_EN).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- disp_data  input  32  word from the selector; digit i shows disp_data[4i+3:4i].
- point  input  8  point[i]=1 lights the decimal point of digit i.
- les  input  8  les[i]=1 marks digit i as blinking.
- an  output  8  digit enables, active-low; an[i]=0 while digit i is driven.
- seg  output  8  segments, active-low; seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a.

## Operation
- Prescaler: SCAN_DIV-bit up-counter, free-running. A "tick" is the cycle where the prescaler is all-ones. The counter wraps to 0 after the tick.
- Digit index idx (3 bits): increments on each tick and wraps 7→0.
- Shadow registers hold data, pt and le (32 + 8 + 8 bits).
  - They load disp_data, point and les on the tick where idx=7, i.e. the same edge that moves idx to 0.
  - They also load on the first clock edge after reset is released (load_pending flag, set by rst, cleared by that load).
  - At every other time the inputs are ignored; changes mid-frame appear at the next frame.
- Output registers, updated every cycle from the current idx and shadow:
  - an <= ~(8'b1 << idx)
  - seg <= {~pt[idx], ~hex(data[4idx+3:4idx])}
- hex() encodes segments g..a, active-high before inversion:
  - 0: 0111111
  - 1: 0000110
  - 2: 1011011
  - 3: 1001111
  - 4: 1100110
  - 5: 1101101
  - 6: 1111101
  - 7: 0000111
  - 8: 1111111
  - 9: 1101111
  - A: 1110111
  - b: 1111100
  - C: 0111001
  - d: 1011110
  - E: 1111001
  - F: 1110001
- Blanking (SEG7_BLINK_EN only): if le[idx]=1 and the blink phase is 1, then seg <= 8'hFF. an is unchanged in this case.

## Timing
- Reset values: an=8'hFF, seg=8'hFF, idx=0, prescaler=0, shadow=0, blink counter=0, load_pending=1.
- Edge E0 is the first edge with rst=0:
  - shadow loads.
  - an and seg remain FF.
- Edge E1: an=8'hFE, seg shows digit 0. Output latency is 1 cycle from any idx or shadow change.
- Digit i is active for exactly 2^SCAN_DIV cycles. One frame is 8·2^SCAN_DIV cycles.
- Frame-boundary load and idx 7→0 occur on the same edge. The next cycle displays digit 0 of the new data.
- rst asserted mid-frame: on the next edge every register returns to its reset value. The sequence then restarts as from E0.
- rst has priority over the tick and over shadow loading.

## Configuration
- SEG7_BLINK_EN defined:
  - A BLINK_DIV-bit free-running counter is instantiated.
  - Digits with le[idx]=1 are blanked while the counter MSB is 1 (50% duty, period 2^BLINK_DIV cycles).
- SEG7_BLINK_EN undefined:
  - No blink counter is instantiated.
  - les is still shadowed but has no effect; every digit is always lit.

## Test plan
Use SCAN_DIV=2 (4 cycles per digit) and BLINK_DIV=4 in simulation.
- Reset sequence: hold rst 3 cycles with disp_data=32'h0123_4567, point=0 → during reset and at E0 an=FF, seg=FF. At E1 an=FE, seg=8'hF8 (digit '7'). Four cycles later an=FD, seg=8'h82 ('6').
- Full frame: disp_data=32'h89AB_CDEF → seg steps through 0x8E, 0x86, 0xA1, 0xC6, 0x83, 0x88, 0x90, 0x80 as an walks FE→7F, then returns to FE.
- No tearing: change disp_data from 32'h0 to 32'hFFFF_FFFF while idx=3 → digits 3–7 still show '0' (seg=0xC0). From the next idx=0 every digit shows 0x8E.
- Decimal point: point=8'h01, data digit 0 = 1 → while an=FE, seg=8'h79. Other digits keep seg[7]=1.
- Mid-frame reset: assert rst while idx=5 for 1 cycle → next edge an=FF and seg=FF. The frame restarts at digit 0 and the shadow reloads on E0.
- Blink (macro defined): les=8'h01 → while an=FE, seg alternates between the digit pattern and 8'hFF every 8 cycles. Other digits stay steady. With the macro undefined, digit 0 is never blanked.
